// File: rtl/picomips_ctrl.sv
// Multi-cycle control sequencer for the 20-bit picoMIPS (FETCH/EXEC/WAIT/HALT).
// Define PICOMIPS_MUL_EN to decode MUL/MULI; otherwise opcodes 5/6 retire as NOP.
module picomips_ctrl #(
  parameter int n = 8
) (
  input  logic         clk,
  input  logic         nReset,
  input  logic [19:0]  instr,
  input  logic [3:0]   flags,
  input  logic         sw_go,
  output logic [2:0]   func,
  output logic         imm_sel,
  output logic         in_sel,
  output logic         reg_we,
  output logic [2:0]   rd_addr,
  output logic [2:0]   rs_addr,
  output logic [n-1:0] imm,
  output logic         pc_inc,
  output logic         pc_load,
  output logic [n-1:0] pc_target,
  output logic [3:0]   flag_q,
  output logic         halted
);

  localparam logic [2:0] RNOP = 3'd0;
  localparam logic [2:0] RADD = 3'd1;
  localparam logic [2:0] RSUB = 3'd2;

  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_ADDI = 4'd2;
  localparam logic [3:0] OP_SUB  = 4'd3;
  localparam logic [3:0] OP_SUBI = 4'd4;
  localparam logic [3:0] OP_BR   = 4'd7;
  localparam logic [3:0] OP_WAIT = 4'd8;
  localparam logic [3:0] OP_HALT = 4'd9;
`ifdef PICOMIPS_MUL_EN
  localparam logic [2:0] RMUL    = 3'd3;
  localparam logic [3:0] OP_MUL  = 4'd5;
  localparam logic [3:0] OP_MULI = 4'd6;
`endif

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_WAIT  = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [19:0] ir_q, ir_d;
  logic [3:0]  flag_d;
  logic [3:0]  op_s;
  logic [1:0]  cond_s;
  logic        br_taken_s;

  assign op_s      = ir_q[19:16];
  assign cond_s    = ir_q[9:8];
  assign rd_addr   = ir_q[15:13];
  assign rs_addr   = ir_q[12:10];
  assign imm       = ir_q[n-1:0];
  assign pc_target = ir_q[n-1:0];
  assign halted    = (state_q == S_HALT);

  // Branch condition on stored flags {N,Z,C,V}
  always_comb begin
    case (cond_s)
      2'b00:   br_taken_s = 1'b1;
      2'b01:   br_taken_s = flag_q[2];
      2'b10:   br_taken_s = ~flag_q[2];
      2'b11:   br_taken_s = flag_q[3];
      default: br_taken_s = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state_q <= S_FETCH;
      ir_q    <= 20'd0;
      flag_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      flag_q  <= flag_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    flag_d  = flag_q;
    func    = RNOP;
    imm_sel = 1'b0;
    in_sel  = 1'b0;
    reg_we  = 1'b0;
    pc_inc  = 1'b0;
    pc_load = 1'b0;
    case (state_q)
      S_FETCH: begin
        ir_d    = instr;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        state_d = S_FETCH;
        case (op_s)
          OP_ADD, OP_ADDI: begin
            func    = RADD;
            imm_sel = (op_s == OP_ADDI);
            reg_we  = 1'b1;
            pc_inc  = 1'b1;
            flag_d  = flags;
          end
          OP_SUB, OP_SUBI: begin
            func    = RSUB;
            imm_sel = (op_s == OP_SUBI);
            reg_we  = 1'b1;
            pc_inc  = 1'b1;
            flag_d  = flags;
          end
`ifdef PICOMIPS_MUL_EN
          OP_MUL, OP_MULI: begin
            func    = RMUL;
            imm_sel = (op_s == OP_MULI);
            reg_we  = 1'b1;
            pc_inc  = 1'b1;
            flag_d  = flags;
          end
`endif
          OP_BR: begin
            if (br_taken_s) begin
              pc_load = 1'b1;
            end else begin
              pc_inc = 1'b1;
            end
          end
          OP_WAIT: state_d = S_WAIT;
          OP_HALT: state_d = S_HALT;
          // NOP and illegal opcodes just advance the PC
          default: pc_inc = 1'b1;
        endcase
      end
      S_WAIT: begin
        if (sw_go) begin
          in_sel  = 1'b1;
          reg_we  = 1'b1;
          pc_inc  = 1'b1;
          state_d = S_FETCH;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

endmodule

// File: tb/tb_picomips_ctrl.sv
// Directed self-checking bench for picomips_ctrl; control outputs are compared
// as a packed vector {func, imm_sel, in_sel, reg_we, pc_inc, pc_load, halted}.
module tb_picomips_ctrl;

  localparam logic [2:0] RNOP = 3'd0;
  localparam logic [2:0] RADD = 3'd1;
  localparam logic [2:0] RSUB = 3'd2;
  localparam logic [2:0] RMUL = 3'd3;

  logic        clk = 1'b0;
  logic        nReset = 1'b0;
  logic [19:0] instr = 20'd0;
  logic [3:0]  flags = 4'd0;
  logic        sw_go = 1'b0;
  logic [2:0]  func;
  logic        imm_sel, in_sel, reg_we, pc_inc, pc_load, halted;
  logic [2:0]  rd_addr, rs_addr;
  logic [7:0]  imm, pc_target;
  logic [3:0]  flag_q;

  int tests = 0;
  int fails = 0;

  picomips_ctrl #(.n(8)) dut (
    .clk(clk), .nReset(nReset), .instr(instr), .flags(flags), .sw_go(sw_go),
    .func(func), .imm_sel(imm_sel), .in_sel(in_sel), .reg_we(reg_we),
    .rd_addr(rd_addr), .rs_addr(rs_addr), .imm(imm), .pc_inc(pc_inc),
    .pc_load(pc_load), .pc_target(pc_target), .flag_q(flag_q), .halted(halted)
  );

  always #5 clk = ~clk;

  function automatic logic [19:0] mk(input logic [3:0] op, input logic [2:0] rd,
                                     input logic [2:0] rs, input logic [1:0] cond,
                                     input logic [7:0] im);
    return {op, rd, rs, cond, im};
  endfunction

  function automatic logic [8:0] ctl(input logic [2:0] f, input logic is, input logic ins,
                                     input logic we, input logic inc, input logic ld,
                                     input logic h);
    return {f, is, ins, we, inc, ld, h};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  logic [8:0] ctl_s;
  assign ctl_s = {func, imm_sel, in_sel, reg_we, pc_inc, pc_load, halted};

  logic [8:0] idle;
  assign idle = ctl(RNOP, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

  initial begin
    tick();
    tick();
    chk("reset_ctl", ctl_s, idle);
    chk("reset_flag", flag_q, 4'd0);
    chk("reset_ir", {rd_addr, rs_addr, imm}, 14'd0);
    nReset = 1'b1;

    // ADDI rd=2 imm=5
    instr = mk(4'd2, 3'd2, 3'd0, 2'b00, 8'h05);
    flags = 4'b0000;
    chk("fetch_idle", ctl_s, idle);
    tick();
    chk("addi_ctl", ctl_s, ctl(RADD, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0));
    chk("addi_rd", rd_addr, 3'd2);
    chk("addi_imm", imm, 8'h05);
    tick();
    chk("addi_back_fetch", ctl_s, idle);
    chk("addi_flag", flag_q, 4'b0000);

    // SUB rd=3 rs=1 producing Z
    instr = mk(4'd3, 3'd3, 3'd1, 2'b00, 8'h00);
    flags = 4'b0100;
    tick();
    chk("sub_ctl", ctl_s, ctl(RSUB, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0));
    chk("sub_rs", rs_addr, 3'd1);
    tick();
    chk("sub_flag", flag_q, 4'b0100);

    // BR Z taken
    flags = 4'b1111;
    instr = mk(4'd7, 3'd0, 3'd0, 2'b01, 8'h10);
    tick();
    chk("brz_taken_ctl", ctl_s, ctl(RNOP, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
    chk("brz_target", pc_target, 8'h10);
    tick();
    chk("br_flag_kept", flag_q, 4'b0100);

    // SUB clearing flags, then BR Z not taken, BR !Z taken, BR N not taken
    instr = mk(4'd3, 3'd3, 3'd1, 2'b00, 8'h00);
    flags = 4'b0000;
    tick();
    tick();
    chk("sub2_flag", flag_q, 4'b0000);
    instr = mk(4'd7, 3'd0, 3'd0, 2'b01, 8'h10);
    tick();
    chk("brz_not_taken", ctl_s, ctl(RNOP, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
    tick();
    instr = mk(4'd7, 3'd0, 3'd0, 2'b10, 8'h20);
    tick();
    chk("brnz_taken", ctl_s, ctl(RNOP, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
    tick();
    instr = mk(4'd7, 3'd0, 3'd0, 2'b11, 8'h30);
    tick();
    chk("brn_not_taken", ctl_s, ctl(RNOP, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
    tick();

    // ADDI capturing N|V, then reset mid-EXEC of ADD
    instr = mk(4'd2, 3'd1, 3'd0, 2'b00, 8'h01);
    flags = 4'b1001;
    tick();
    tick();
    chk("addi_flag_nv", flag_q, 4'b1001);
    instr = mk(4'd1, 3'd4, 3'd2, 2'b00, 8'h00);
    flags = 4'b0110;
    tick();
    chk("add_ctl", ctl_s, ctl(RADD, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0));
    #2;
    nReset = 1'b0;
    #1;
    chk("midexec_rst_ctl", ctl_s, idle);
    chk("midexec_rst_flag", flag_q, 4'd0);
    instr = mk(4'd2, 3'd5, 3'd0, 2'b00, 8'h22);
    flags = 4'b1000;
    tick();
    nReset = 1'b1;
    chk("rst_hold_ctl", ctl_s, idle);
    tick();
    chk("post_rst_rd", rd_addr, 3'd5);
    chk("post_rst_imm", imm, 8'h22);
    chk("post_rst_ctl", ctl_s, ctl(RADD, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0));
    tick();
    chk("post_rst_flag", flag_q, 4'b1000);

    // WAIT with 5 stall cycles
    instr = mk(4'd8, 3'd4, 3'd0, 2'b00, 8'h00);
    tick();
    chk("wait_exec_ctl", ctl_s, idle);
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("wait_stall_ctl", ctl_s, idle);
      tick();
    end
    sw_go = 1'b1;
    #1;
    chk("wait_go_ctl", ctl_s, ctl(RNOP, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0));
    chk("wait_rd", rd_addr, 3'd4);
    tick();
    sw_go = 1'b0;
    chk("wait_done_fetch", ctl_s, idle);
    chk("wait_flag_kept", flag_q, 4'b1000);

    // MULI imm=0x40
    instr = mk(4'd6, 3'd1, 3'd0, 2'b00, 8'h40);
    flags = 4'b0010;
    tick();
`ifdef PICOMIPS_MUL_EN
    chk("muli_ctl", ctl_s, ctl(RMUL, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0));
    tick();
    chk("muli_flag", flag_q, 4'b0010);
`else
    chk("muli_ctl", ctl_s, ctl(RNOP, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
    tick();
    chk("muli_flag", flag_q, 4'b1000);
`endif

    // Illegal opcode 0xC then HALT
    instr = mk(4'hC, 3'd7, 3'd7, 2'b11, 8'hFF);
    flags = 4'b0101;
    tick();
    chk("illegal_ctl", ctl_s, ctl(RNOP, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
    tick();
    instr = mk(4'd9, 3'd0, 3'd0, 2'b00, 8'h00);
    tick();
    chk("halt_exec_ctl", ctl_s, idle);
    tick();
    sw_go = 1'b1;
    for (int i = 0; i < 20; i++) begin
      chk("halted_ctl", ctl_s, ctl(RNOP, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
      tick();
    end
    sw_go = 1'b0;
    nReset = 1'b0;
    #1;
    chk("halt_rst_ctl", ctl_s, idle);
    tick();
    nReset = 1'b1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
